// File: rtl/counter_pkg.sv
// Shared types and defaults for the counter family (up-counter and down-counter timer).
package counter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tmr_state_t;

  localparam int CNT_W_DEFAULT = 8;

endpackage

// File: rtl/borrow_cell.sv
// One bit of a ripple-borrow decrementer; chained LSB to MSB.
module borrow_cell (
  input  logic q_i,
  input  logic borrow_in,
  output logic diff_o,
  output logic borrow_out
);

  assign diff_o     = q_i ^ borrow_in;
  assign borrow_out = ~q_i & borrow_in;

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counter / terminal-count timer with one-shot and periodic modes.
module down_counter_timer
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             periodic,
  output logic [WIDTH-1:0] q,
  output logic             running,
  output logic             zero,
  output logic             tc
);

  tmr_state_t       state;
  tmr_state_t       state_next;
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] diff;
  logic [WIDTH:0]   borrow;
  logic             dec_en;
  logic             at_tc;

  // A decrement is requested only while running, enabled and not overridden by a load.
  assign dec_en    = (state == RUN) & enable & ~load;
  assign at_tc     = dec_en & (q == WIDTH'(1));
  assign borrow[0] = dec_en;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_dec
      borrow_cell u_cell (
        .q_i        (q[i]),
        .borrow_in  (borrow[i]),
        .diff_o     (diff[i]),
        .borrow_out (borrow[i+1])
      );
    end
  endgenerate

  // Next-count and next-state selection: load > terminal count > decrement > hold.
  // A borrow out of the MSB would mean decrementing from zero; that case holds q.
  always_comb begin
    q_next     = q;
    state_next = state;
    if (load) begin
      q_next     = d;
      state_next = (d != '0) ? RUN : IDLE;
    end else if (at_tc) begin
      if (periodic) begin
        q_next = reload;
      end else begin
        q_next     = '0;
        state_next = IDLE;
      end
    end else if (dec_en && !borrow[WIDTH]) begin
      q_next = diff;
    end
  end

  // Registered count, reload value, state and outputs; async reset clears everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q       <= '0;
      reload  <= '0;
      state   <= IDLE;
      running <= 1'b0;
      tc      <= 1'b0;
    end else begin
      q       <= q_next;
      state   <= state_next;
      running <= (state_next == RUN);
      tc      <= at_tc;
      if (load) begin
        reload <= d;
      end
    end
  end

  assign zero = (q == '0);

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench: behavioural timer model, per-cycle compare, directed and random stimulus.
module tb_down_counter_timer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] d = '0;
  logic         periodic = 1'b0;
  logic [W-1:0] q;
  logic         running;
  logic         zero;
  logic         tc;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  int mq = 0;
  int mrel = 0;
  int mrun = 0;
  int mtc = 0;

  down_counter_timer #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .load     (load),
    .d        (d),
    .periodic (periodic),
    .q        (q),
    .running  (running),
    .zero     (zero),
    .tc       (tc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: timer rules in plain integer arithmetic.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq = 0; mrel = 0; mrun = 0; mtc = 0;
    end else if (load) begin
      mq = int'(d); mrel = int'(d); mtc = 0; mrun = (d != 0) ? 1 : 0;
    end else if (mrun == 1 && enable) begin
      if (mq == 1) begin
        mtc = 1;
        if (periodic) mq = mrel;
        else begin mq = 0; mrun = 0; end
      end else begin
        mq = mq - 1; mtc = 0;
      end
    end else begin
      mtc = 0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("q", int'(q), mq);
    check("running", int'(running), mrun);
    check("zero", int'(zero), (mq == 0) ? 1 : 0);
    check("tc", int'(tc), mtc);
  end

  // Apply one cycle of inputs; returns at posedge+1.
  task automatic step(input logic ld, input logic [W-1:0] dv, input logic en, input logic per);
    load = ld; d = dv; enable = en; periodic = per;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int tcs;
    int cnt;
    bit seen;

    // Reset held
    repeat (2) @(posedge clk);
    #1;
    check("rst_q", int'(q), 0);
    check("rst_running", int'(running), 0);
    check("rst_tc", int'(tc), 0);
    reset = 1'b0;

    // Reset mid-count
    step(1'b1, 8'd10, 1'b0, 1'b0);
    repeat (4) step(1'b0, 8'd0, 1'b1, 1'b0);
    check("mid_q6", int'(q), 6);
    #2 reset = 1'b1;
    #1;
    check("async_q", int'(q), 0);
    check("async_running", int'(running), 0);
    check("async_tc", int'(tc), 0);
    @(posedge clk);
    #3 reset = 1'b0;
    seen = 0;
    repeat (6) begin
      step(1'b0, 8'd0, 1'b1, 1'b0);
      if (tc) seen = 1;
    end
    check("post_rst_no_tc", int'(seen), 0);
    check("post_rst_q", int'(q), 0);

    // One-shot load 3
    step(1'b1, 8'd3, 1'b1, 1'b0);
    check("os_q3", int'(q), 3);
    check("os_run", int'(running), 1);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    check("os_q2", int'(q), 2);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    check("os_q1", int'(q), 1);
    check("os_tc_early", int'(tc), 0);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    check("os_q0", int'(q), 0);
    check("os_tc", int'(tc), 1);
    check("os_run_drop", int'(running), 0);
    seen = 0;
    repeat (5) begin
      step(1'b0, 8'd0, 1'b1, 1'b0);
      if (tc || q != 0) seen = 1;
    end
    check("os_stay0", int'(seen), 0);

    // Periodic load 4, 12 enabled cycles
    step(1'b1, 8'd4, 1'b0, 1'b1);
    tcs = 0;
    repeat (12) begin
      step(1'b0, 8'd0, 1'b1, 1'b1);
      if (tc) begin
        tcs++;
        check("per_tc_q4", int'(q), 4);
      end
    end
    check("per_tcs", tcs, 3);
    check("per_q_end", int'(q), 4);

    // Pause and load priority
    step(1'b1, 8'd5, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    check("pause_q4a", int'(q), 4);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    check("pause_q4b", int'(q), 4);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    check("pause_q4c", int'(q), 4);
    check("pause_run", int'(running), 1);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    check("pause_q3", int'(q), 3);
    step(1'b1, 8'd9, 1'b1, 1'b0);
    check("prio_q9", int'(q), 9);
    check("prio_tc", int'(tc), 0);

    // Load zero
    step(1'b1, 8'd0, 1'b1, 1'b0);
    check("z_running", int'(running), 0);
    check("z_zero", int'(zero), 1);
    check("z_tc", int'(tc), 0);

    // Load 255 one-shot
    step(1'b1, 8'd255, 1'b0, 1'b0);
    cnt = 0;
    seen = 0;
    while (cnt < 300 && !seen) begin
      step(1'b0, 8'd0, 1'b1, 1'b0);
      cnt++;
      if (tc) seen = 1;
    end
    check("ff_cycles", cnt, 255);
    check("ff_q0", int'(q), 0);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    check("ff_no_underflow", int'(q), 0);

    // Load 1 periodic
    step(1'b1, 8'd1, 1'b0, 1'b1);
    tcs = 0;
    repeat (5) begin
      step(1'b0, 8'd0, 1'b1, 1'b1);
      if (tc && q == 1) tcs++;
    end
    check("one_per_tcs", tcs, 5);

    // Random stimulus
    for (int n = 0; n < 2000; n++) begin
      logic         ld;
      logic [W-1:0] dv;
      ld = ($urandom_range(0, 15) == 0);
      dv = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
      step(ld, dv, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b1;
        #4 reset = 1'b0;
      end
    end

    load = 1'b0;
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
